// File: rtl/sgbm_ctrl_pkg.sv
// Shared types and defaults for the SGBM frame controller.
// Holds the FSM encoding and the frame dimension clamp helper.
package sgbm_ctrl_pkg;

  localparam int DEF_IMG_ROW = 200;
  localparam int DEF_IMG_COL = 400;
  localparam int DEF_ROW_W   = 10;
  localparam int DEF_COL_W   = 10;
  localparam int DEF_CNT_W   = 20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  // Zero or oversize requests fall back to the full frame.
  function automatic logic [15:0] clamp_dim(
    input logic [15:0] cfg,
    input logic [15:0] lim
  );
    return (cfg == '0 || cfg > lim) ? lim : cfg;
  endfunction

endpackage

// File: rtl/sgbm_raster_cnt.sv
// Raster-order row/col counter with programmable limits.
// Wraps to (0,0) after the last pixel of the frame.
module sgbm_raster_cnt #(
  parameter int ROW_W = 10,
  parameter int COL_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [ROW_W-1:0] rows,
  input  logic [COL_W-1:0] cols,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             eol,
  output logic             last
);

  assign eol  = (col == cols - COL_W'(1));
  assign last = eol && (row == rows - ROW_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (eol) begin
        col <= '0;
        row <= last ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/sgbm_frame_ctrl.sv
// Frame sequencer: issues raster pixel requests and checks results.
// Define SGBM_CTRL_WDOG_EN to enable the stall watchdog.
module sgbm_frame_ctrl
  import sgbm_ctrl_pkg::*;
#(
  parameter int IMG_ROW      = DEF_IMG_ROW,
  parameter int IMG_COL      = DEF_IMG_COL,
  parameter int ROW_W        = DEF_ROW_W,
  parameter int COL_W        = DEF_COL_W,
  parameter int MAX_INFLIGHT = 64,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int WDOG_CYC     = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ROW_W-1:0] cfg_rows,
  input  logic [COL_W-1:0] cfg_cols,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             timeout,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [ROW_W-1:0] pix_row,
  output logic [COL_W-1:0] pix_col,
  output logic             pix_sof,
  output logic             pix_eol,
  input  logic             res_valid,
  input  logic [ROW_W-1:0] res_row,
  input  logic [COL_W-1:0] res_col,
  output logic [CNT_W-1:0] out_cnt
);

  localparam int IFW = $clog2(MAX_INFLIGHT + 1);

  state_t           state, state_n;
  logic [ROW_W-1:0] rows_q, rows_c;
  logic [COL_W-1:0] cols_q, cols_c;
  logic [CNT_W-1:0] total_q, out_cnt_n;
  logic [IFW-1:0]   inflight, inflight_n;
  logic             pv_n, xfer, accept;
  logic             res_act, full, res_cnt;
  logic             dec, mism, res_err;
  logic             iss_eol, iss_last, wd_fire;
  logic [ROW_W-1:0] exp_row;
  logic [COL_W-1:0] exp_col;
  logic             unused_exp_eol;
  logic             unused_exp_last;

  assign rows_c = ROW_W'(clamp_dim(16'(cfg_rows), 16'(IMG_ROW)));
  assign cols_c = COL_W'(clamp_dim(16'(cfg_cols), 16'(IMG_COL)));

  assign accept  = (state == S_IDLE) && start;
  assign xfer    = pix_valid && pix_ready;
  assign res_act = (state == S_ISSUE) || (state == S_DRAIN);
  assign full    = (out_cnt == total_q);
  assign res_cnt = res_valid && res_act && !full;
  assign dec     = res_valid && res_act && (inflight != '0);
  assign mism    = res_cnt &&
                   (res_row != exp_row || res_col != exp_col);
  assign res_err = res_valid &&
                   (!res_act || full || inflight == '0 || mism);

  assign out_cnt_n  = out_cnt + CNT_W'(res_cnt);
  assign inflight_n = inflight + IFW'(xfer) - IFW'(dec);

  sgbm_raster_cnt #(.ROW_W(ROW_W), .COL_W(COL_W)) u_issue (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == S_LOAD),
    .en   (xfer),
    .rows (rows_q),
    .cols (cols_q),
    .row  (pix_row),
    .col  (pix_col),
    .eol  (iss_eol),
    .last (iss_last)
  );

  sgbm_raster_cnt #(.ROW_W(ROW_W), .COL_W(COL_W)) u_expect (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == S_LOAD),
    .en   (res_cnt),
    .rows (rows_q),
    .cols (cols_q),
    .row  (exp_row),
    .col  (exp_col),
    .eol  (unused_exp_eol),
    .last (unused_exp_last)
  );

  assign busy    = state inside {S_LOAD, S_ISSUE, S_DRAIN};
  assign done    = (state == S_DONE);
  assign pix_sof = pix_valid && pix_row == '0 && pix_col == '0;
  assign pix_eol = pix_valid && iss_eol;

  always_comb begin
    state_n = state;
    pv_n    = pix_valid;
    unique case (state)
      S_IDLE:  if (start) state_n = S_LOAD;
      S_LOAD: begin
        state_n = S_ISSUE;
        pv_n    = 1'b1;
      end
      S_ISSUE: begin
        if (xfer && iss_last) begin
          pv_n    = 1'b0;
          state_n = S_DRAIN;
        end else if (xfer || !pix_valid) begin
          pv_n = int'(inflight_n) < MAX_INFLIGHT;
        end
      end
      S_DRAIN: if (out_cnt_n == total_q) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (wd_fire) begin
      state_n = S_DONE;
      pv_n    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      pix_valid <= 1'b0;
      err       <= 1'b0;
      out_cnt   <= '0;
      inflight  <= '0;
      rows_q    <= '0;
      cols_q    <= '0;
      total_q   <= '0;
    end else begin
      state     <= state_n;
      pix_valid <= pv_n;
      if (accept) begin
        err      <= 1'b0;
        out_cnt  <= '0;
        inflight <= '0;
      end else begin
        if (res_err || wd_fire) err <= 1'b1;
        out_cnt  <= out_cnt_n;
        inflight <= inflight_n;
      end
      if (state == S_LOAD) begin
        rows_q  <= rows_c;
        cols_q  <= cols_c;
        total_q <= CNT_W'(rows_c) * CNT_W'(cols_c);
      end
    end
  end

`ifdef SGBM_CTRL_WDOG_EN
  localparam int WDW = $clog2(WDOG_CYC + 1);

  logic [WDW-1:0] wd;
  logic           to_q;

  assign wd_fire = res_act && !xfer && !res_valid &&
                   int'(wd) == WDOG_CYC - 1;
  assign timeout = to_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd   <= '0;
      to_q <= 1'b0;
    end else begin
      if (accept) to_q <= 1'b0;
      else if (wd_fire) to_q <= 1'b1;
      if (!res_act || xfer || res_valid || wd_fire) wd <= '0;
      else wd <= wd + WDW'(1);
    end
  end
`else
  localparam int UNUSED_WDOG = WDOG_CYC;

  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sgbm_frame_ctrl.sv
// Directed bench for sgbm_frame_ctrl with a raster scoreboard.
// Build with SGBM_CTRL_WDOG_EN to also exercise the watchdog.
module tb_sgbm_frame_ctrl;

  localparam int RW   = 10;
  localparam int CW   = 10;
  localparam int NW   = 20;
  localparam int MAXI = 4;
  localparam int LAT  = 3;

  logic          clk = 0;
  logic          rst = 0;
  logic          start = 0;
  logic [RW-1:0] cfg_rows = '0;
  logic [CW-1:0] cfg_cols = '0;
  logic          busy, done, err, timeout;
  logic          pix_valid, pix_sof, pix_eol;
  logic          pix_ready = 0;
  logic [RW-1:0] pix_row;
  logic [CW-1:0] pix_col;
  logic          res_valid = 0;
  logic [RW-1:0] res_row = '0;
  logic [CW-1:0] res_col = '0;
  logic [NW-1:0] out_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int r;
    int c;
    int t;
  } ent_t;

  ent_t q[$];

  always #5 clk = ~clk;

  sgbm_frame_ctrl #(
    .IMG_ROW      (6),
    .IMG_COL      (7),
    .ROW_W        (RW),
    .COL_W        (CW),
    .MAX_INFLIGHT (MAXI),
    .CNT_W        (NW),
    .WDOG_CYC     (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_rows  (cfg_rows),
    .cfg_cols  (cfg_cols),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .timeout   (timeout),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_row   (pix_row),
    .pix_col   (pix_col),
    .pix_sof   (pix_sof),
    .pix_eol   (pix_eol),
    .res_valid (res_valid),
    .res_row   (res_row),
    .res_col   (res_col),
    .out_cnt   (out_cnt)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic run_frame(
    input int cr, input int cc,
    input int er, input int ec,
    input bit bp, input bit hold_in,
    input int bad_idx, input bit exp_err
  );
    int n = 0, nx = 0, nres = 0, dones = 0;
    int bad = 0, stab = 0, cred = 0, minf = 0;
    int xr = 0, xc = 0, stall = 0, pr = 0, pc = 0;
    bit pv_prev = 0, rdy_prev = 0, fin = 0;
    bit hold = hold_in, rel = 0, rise = 0;
    bit rdy, xf, rv;
    q.delete();
    @(negedge clk);
    cfg_rows = RW'(cr);
    cfg_cols = CW'(cc);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("busy_on", busy, 1);
    chk("err_clr", err, 0);
    chk("cnt_clr", out_cnt, 0);
    while (!fin && n < 3000) begin
      res_valid = 0;
      if (done) begin
        dones++;
        if (busy) bad++;
        pix_ready = 0;
        fin = 1;
        break;
      end
      if (pv_prev && !rdy_prev &&
          (!pix_valid || pix_row != RW'(pr) ||
           pix_col != CW'(pc))) stab++;
      if (pix_valid && minf >= MAXI) cred++;
      if (rise) begin
        chk("credit_rise", pix_valid, 1);
        rise = 0;
      end
      rdy = bp ? (n % 4 == 0 || n % 4 == 3) : 1'b1;
      pix_ready = rdy;
      xf = pix_valid && rdy;
      if (xf) begin
        if (pix_row != RW'(xr) || pix_col != CW'(xc) ||
            pix_sof != (xr == 0 && xc == 0) ||
            pix_eol != (xc == ec - 1)) bad++;
        q.push_back('{xr, xc, n});
        nx++;
        if (xc == ec - 1) begin
          xc = 0;
          xr++;
        end else xc++;
      end
      if (hold && nx >= MAXI) begin
        stall++;
        if (stall == 5) begin
          chk("credit_stall", pix_valid, 0);
          hold = 0;
          rel = 1;
        end
      end
      rv = 0;
      if (!hold && q.size() > 0 && q[0].t + LAT <= n) begin
        rv = 1;
        res_valid = 1;
        res_row = RW'(q[0].r);
        res_col = CW'(q[0].c);
        if (nres == bad_idx) begin
          res_row = '0;
          res_col = '0;
        end
        void'(q.pop_front());
        nres++;
        if (rel) begin
          rise = 1;
          rel = 0;
        end
      end
      minf += int'(xf) - int'(rv);
      pv_prev = pix_valid;
      rdy_prev = rdy;
      pr = pix_row;
      pc = pix_col;
      n++;
      @(negedge clk);
    end
    res_valid = 0;
    chk("frame_end", fin, 1);
    chk("xfers", nx, er * ec);
    chk("order", bad, 0);
    chk("stable", stab, 0);
    chk("credit", cred, 0);
    chk("dones", dones, 1);
    chk("out_cnt", out_cnt, er * ec);
    chk("err", err, exp_err);
    @(negedge clk);
    chk("done_once", done, 0);
    chk("idle_busy", busy, 0);
  endtask

`ifdef SGBM_CTRL_WDOG_EN
  task automatic wdog_test();
    int nx = 0, k = 0, d = -1;
    @(negedge clk);
    cfg_rows = 4;
    cfg_cols = 5;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 60 && d < 0; i++) begin
      if (done) d = i;
      else begin
        pix_ready = (nx < 3);
        if (pix_valid && pix_ready) begin
          nx++;
          k = i;
        end
        @(negedge clk);
      end
    end
    pix_ready = 0;
    chk("wdog_xfers", nx, 3);
    chk("wdog_gap", d - k, 17);
    chk("wdog_flags", {timeout, err, pix_valid}, 3'b110);
    @(negedge clk);
    chk("wdog_idle", {busy, done}, 0);
  endtask
`endif

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_flags", {busy, done, err, timeout,
        pix_valid, pix_sof, pix_eol}, 0);
    chk("rst_coord", {pix_row, pix_col}, 0);
    chk("rst_cnt", out_cnt, 0);
    rst = 1;
    run_frame(4, 5, 4, 5, 0, 0, -1, 0);
    run_frame(4, 5, 4, 5, 1, 0, -1, 0);
    run_frame(4, 5, 4, 5, 0, 1, -1, 0);
    run_frame(4, 5, 4, 5, 0, 0, 1, 1);
    run_frame(0, 999, 6, 7, 0, 0, -1, 0);
    @(negedge clk);
    res_valid = 1;
    res_row = '0;
    res_col = '0;
    @(negedge clk);
    res_valid = 0;
    chk("spur_err", err, 1);
    chk("spur_cnt", out_cnt, 42);
    @(negedge clk);
    cfg_rows = 4;
    cfg_cols = 5;
    start = 1;
    @(negedge clk);
    start = 0;
    pix_ready = 1;
    repeat (4) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 0;
    #1;
    chk("mid_flags", {busy, done, err, pix_valid}, 0);
    chk("mid_coord", {pix_row, pix_col}, 0);
    chk("mid_cnt", out_cnt, 0);
    pix_ready = 0;
    @(negedge clk);
    chk("mid_nodone", done, 0);
    rst = 1;
    run_frame(2, 3, 2, 3, 1, 0, -1, 0);
`ifdef SGBM_CTRL_WDOG_EN
    wdog_test();
`endif
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
